// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Default char-cell video timing constants and count widths shared by the
// sync generator and its axis counters.
package video_timing_pkg;

  localparam int H_VISIBLE_DEF = 132;
  localparam int H_FRONT_DEF   = 3;
  localparam int H_SYNC_DEF    = 17;
  localparam int H_BACK_DEF    = 24;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 1;
  localparam int V_SYNC_DEF    = 4;
  localparam int V_BACK_DEF    = 23;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int CHAR_W = 8;
  localparam int LINE_W = 12;
  // All position compares are done at this width, counts zero-extended.
  localparam int CMP_W  = 12;

endpackage

// File: rtl/sync_axis_counter.sv
// sync_axis_counter
// One timing axis (horizontal or vertical): a wrapping up-counter with
// a registered "next position is visible" flag and a registered sync flag
// that lags the count by one cycle.
// Ports:
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   enable      in   advance the count this edge
//   count       out  current position 0..TOTAL-1
//   wrap        out  count is at TOTAL-1 and enable is high (wraps this edge)
//   visible     out  count is inside the visible region (registered next-state)
//   sync_active out  previous-cycle count was inside the sync region
module sync_axis_counter
  import video_timing_pkg::*;
#(
  parameter int TOTAL      = 176,
  parameter int VISIBLE    = 132,
  parameter int SYNC_START = 135,
  parameter int SYNC_LEN   = 17,
  parameter int W          = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         visible,
  output logic         sync_active
);

  logic [W-1:0]     r_count;
  logic             r_visible;
  logic             r_sync;
  logic [W-1:0]     w_count_next;
  logic [CMP_W-1:0] w_cur_ext;
  logic [CMP_W-1:0] w_next_ext;

  assign w_cur_ext  = CMP_W'(r_count);
  assign w_next_ext = CMP_W'(w_count_next);
  assign wrap       = enable && (w_cur_ext == CMP_W'(TOTAL - 1));

  always_comb begin
    w_count_next = r_count;
    if (enable) begin
      if (wrap) w_count_next = '0;
      else      w_count_next = r_count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_visible <= 1'b0;
      r_sync    <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      // Evaluated on the next count so the flag lines up with that count.
      r_visible <= (w_next_ext < CMP_W'(VISIBLE));
      // Evaluated on the current count: one-cycle lag matches the renderer stage.
      r_sync    <= (w_cur_ext >= CMP_W'(SYNC_START)) &&
                   (w_cur_ext <  CMP_W'(SYNC_START + SYNC_LEN));
    end
  end

  assign count       = r_count;
  assign visible     = r_visible;
  assign sync_active = r_sync;

endmodule

// File: rtl/video_sync_gen.sv
// video_sync_gen
// Timing master for the char-cell video path. Free-running char/line
// counters, pre_visible for the renderer, and hsync/vsync/frame_start
// delayed one char_clock to line up with the renderer's registered pixels.
// Optional feature macro: VIDEO_SYNC_GEN_FRAME_CNT_EN adds a 16-bit
// frame_count output that advances with each frame_start.
// Ports:
//   char_clock  in   char-rate clock
//   reset_n     in   asynchronous active-low reset
//   char_count  out  current char index 0..H_TOTAL-1
//   line_count  out  current line index 0..V_TOTAL-1
//   pre_visible out  current position visible; pixel appears next cycle
//   hsync       out  horizontal sync, active level HSYNC_POL
//   vsync       out  vertical sync, active level VSYNC_POL
//   frame_start out  one-cycle pulse after the first visible char of a frame
//   frame_count out  frames seen, wraps (only with the feature macro)
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic              char_clock,
  input  logic              reset_n,
  output logic [CHAR_W-1:0] char_count,
  output logic [LINE_W-1:0] line_count,
  output logic              pre_visible,
  output logic              hsync,
  output logic              vsync,
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
  output logic              frame_start,
  output logic [15:0]       frame_count
`else
  output logic              frame_start
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 256) begin : g_h_total_chk
      $error("video_sync_gen: H_TOTAL exceeds 8-bit char counter");
    end
    if (V_TOTAL > 4096) begin : g_v_total_chk
      $error("video_sync_gen: V_TOTAL exceeds 12-bit line counter");
    end
  endgenerate

  // Holds the counters at (0,0) for the first edge after reset so that
  // pre_visible can come up before counting starts.
  logic              r_started;
  logic              r_frame_start;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_h_vis;
  logic              w_v_vis;
  logic              w_h_sync;
  logic              w_v_sync;
  logic [CHAR_W-1:0] w_char;
  logic [LINE_W-1:0] w_line;

  sync_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .W          (CHAR_W)
  ) u_h_axis (
    .clk         (char_clock),
    .reset_n     (reset_n),
    .enable      (r_started),
    .count       (w_char),
    .wrap        (w_h_wrap),
    .visible     (w_h_vis),
    .sync_active (w_h_sync)
  );

  sync_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .W          (LINE_W)
  ) u_v_axis (
    .clk         (char_clock),
    .reset_n     (reset_n),
    .enable      (w_h_wrap),
    .count       (w_line),
    .wrap        (w_v_wrap),
    .visible     (w_v_vis),
    .sync_active (w_v_sync)
  );

  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_started     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_started     <= 1'b1;
      r_frame_start <= pre_visible && (w_char == '0) && (w_line == '0);
    end
  end

`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= '0;
    end else if (pre_visible && (w_char == '0) && (w_line == '0)) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

  assign char_count  = w_char;
  assign line_count  = w_line;
  assign pre_visible = w_h_vis & w_v_vis;
  assign hsync       = HSYNC_POL ? w_h_sync : ~w_h_sync;
  assign vsync       = VSYNC_POL ? w_v_sync : ~w_v_sync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen
// Randomized run/reset sequences on video_sync_gen with a shortened vertical
// timing, compared every cycle against a model that derives the expected
// raster position from the number of clock edges since reset release.
module tb_video_sync_gen;

  localparam int HV = 132, HF = 3, HS = 17, HB = 24;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 20, VF = 1, VS = 4, VB = 3;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
  localparam bit H_POL = 1'b0;
`else
  localparam bit H_POL = 1'b1;
`endif
  localparam bit V_POL = 1'b1;

  logic        char_clock = 1'b0;
  logic        reset_n;
  logic [7:0]  char_count;
  logic [11:0] line_count;
  logic        pre_visible, hsync, vsync, frame_start;
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  always #5 char_clock = ~char_clock;

  video_sync_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .HSYNC_POL (H_POL), .VSYNC_POL (V_POL)
  ) dut (
    .char_clock  (char_clock),
    .reset_n     (reset_n),
    .char_count  (char_count),
    .line_count  (line_count),
    .pre_visible (pre_visible),
    .hsync       (hsync),
    .vsync       (vsync),
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
    .frame_start (frame_start),
    .frame_count (frame_count)
`else
    .frame_start (frame_start)
`endif
  );

  int checks = 0;
  int errors = 0;

  int k;              // clock edges since reset release
  logic [15:0] m_fc;  // model frame counter
  int max_line;
  int hs_run, hs_min, hs_max, vs_run, vs_min, vs_max;
  int fs_last, fs_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Linear raster position held after edge kk: edge 1 holds (0,0), then +1 per edge.
  function automatic int pos(input int kk);
    return (kk <= 1) ? 0 : kk - 1;
  endfunction

  function automatic bit exp_fs(input int kk);
    return (kk >= 2) && (((kk - 2) % FRAME) == 0);
  endfunction

  task automatic check_reset();
    chk("rst_char", 32'(char_count), 0);
    chk("rst_line", 32'(line_count), 0);
    chk("rst_pv", 32'(pre_visible), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_hs", 32'(hsync), 32'(!H_POL));
    chk("rst_vs", 32'(vsync), 32'(!V_POL));
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
    chk("rst_fc", 32'(frame_count), 0);
`endif
  endtask

  task automatic check_all();
    int p, c, l, pp, pc, pl;
    bit hs_act, vs_act;
    p  = pos(k);
    c  = p % HT;
    l  = (p / HT) % VT;
    pp = (k >= 1) ? pos(k - 1) : 0;
    pc = pp % HT;
    pl = (pp / HT) % VT;
    hs_act = (k >= 1) && (pc >= HV + HF) && (pc < HV + HF + HS);
    vs_act = (k >= 1) && (pl >= VV + VF) && (pl < VV + VF + VS);
    chk("char", 32'(char_count), 32'(c));
    chk("line", 32'(line_count), 32'(l));
    chk("pre_visible", 32'(pre_visible), 32'((k >= 1) && (c < HV) && (l < VV)));
    chk("hsync", 32'(hsync), 32'(hs_act ? H_POL : !H_POL));
    chk("vsync", 32'(vsync), 32'(vs_act ? V_POL : !V_POL));
    chk("frame_start", 32'(frame_start), 32'(exp_fs(k)));
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
    chk("frame_count", 32'(frame_count), 32'(m_fc));
`endif
  endtask

  task automatic track_runs();
    if (hsync == H_POL) hs_run++;
    else if (hs_run > 0) begin
      if (hs_run < hs_min) hs_min = hs_run;
      if (hs_run > hs_max) hs_max = hs_run;
      hs_run = 0;
    end
    if (vsync == V_POL) vs_run++;
    else if (vs_run > 0) begin
      if (vs_run < vs_min) vs_min = vs_run;
      if (vs_run > vs_max) vs_max = vs_run;
      vs_run = 0;
    end
    if (int'(line_count) > max_line) max_line = int'(line_count);
    if (frame_start === 1'b1) begin
      if (fs_last < 0) chk("fs_first_edge", 32'(k), 2);
      else             chk("fs_interval", 32'(k - fs_last), 32'(FRAME));
      fs_last = k;
      fs_seen++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge char_clock);
      k++;
      if (exp_fs(k)) m_fc = m_fc + 16'd1;
      @(negedge char_clock);
      check_all();
      track_runs();
    end
  endtask

  // Assert reset between edges, verify the asynchronous clear, hold, release.
  task automatic do_reset(input int hold);
    #2 reset_n = 1'b0;
    #1 check_reset();
    for (int i = 0; i < hold; i++) begin
      @(negedge char_clock);
      check_reset();
    end
    reset_n = 1'b1;
    k = 0;
    m_fc = '0;
    hs_run = 0;
    vs_run = 0;
    fs_last = -1;
    check_all();
  endtask

  initial begin
    reset_n  = 1'b0;
    k        = 0;
    m_fc     = '0;
    max_line = 0;
    hs_run = 0; hs_min = 1 << 30; hs_max = 0;
    vs_run = 0; vs_min = 1 << 30; vs_max = 0;
    fs_last = -1;
    fs_seen = 0;

    repeat (5) begin
      @(negedge char_clock);
      check_reset();
    end
    reset_n = 1'b1;
    check_all();

    // Two full frames plus a margin: three frame_start pulses.
    run(2 * FRAME + 200);
    chk("line_max", 32'(max_line), 32'(VT - 1));
    chk("fs_count", 32'(fs_seen), 3);
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
    chk("fc_3frames", 32'(frame_count), 3);
`endif

    // Mid-line reset at (80,10), then a full restart.
    do_reset(1 + int'($urandom_range(0, 3)));
    run(10 * HT + 80 + 1);
    chk("pos_char_80", 32'(char_count), 80);
    chk("pos_line_10", 32'(line_count), 10);
    do_reset(1 + int'($urandom_range(0, 3)));
    run(FRAME + 10);

    // Random run lengths interrupted by resets.
    for (int it = 0; it < 3; it++) begin
      run(int'($urandom_range(1, 3000)));
      do_reset(int'($urandom_range(0, 4)));
    end
    run(FRAME + 50);

`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
    // Counter preload: the next frame_start must wrap it to zero.
    @(negedge char_clock);
    force dut.r_frame_count = 16'hFFFF;
    #1 release dut.r_frame_count;
    m_fc = 16'hFFFF;
    run(FRAME + 5);
    chk("fc_wrap", 32'(frame_count), 0);
`endif

    chk("hs_run_min", 32'(hs_min), 32'(HS));
    chk("hs_run_max", 32'(hs_max), 32'(HS));
    chk("vs_run_min", 32'(vs_min), 32'(VS * HT));
    chk("vs_run_max", 32'(vs_max), 32'(VS * HT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
